uart_frame_loader: RTL

Downstream consumer of the UART receiver in the image down-sampler datapath. It takes completed bytes from the receiver, which runs on the oversampling tick domain, and synchronises the completion flag into the system clock. It packs byte pairs little-endian into 16-bit pixel words and writes them sequentially into the frame buffer RAM. Once a full frame is stored, it hands the frame to the down-sampler with a done/ack handshake and refuses further bytes until acknowledged.

---
 rtl/uart_frame_loader.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/uart_frame_loader.sv
// uart_frame_loader: synchronises the UART receiver completion flag into clk,
// packs byte pairs little-endian into 16-bit words, writes them sequentially
// into the frame buffer and hands each full frame over with a done/ack handshake.
// Optional feature macro: FRAME_LOADER_TIMEOUT_EN (drops a stale low byte after
// TIMEOUT_CYCLES clk cycles in HI).
module uart_frame_loader #(
   parameter int ADDR_W         = 14,
   parameter int FRAME_WORDS    = 16384,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [7:0]        rx_byte,
   input  logic              rx_valid,
   input  logic              frame_ack,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [15:0]       mem_wdata,
   output logic              frame_done,
   output logic              busy,
   output logic              byte_drop
);

   typedef enum logic [1:0] {LO, HI, WR, DONE} state_t;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_WORDS - 1);

   // Synchroniser flops reset high so a flag already high at release is not an edge.
   logic s1_q, s2_q, s3_q;
   logic strobe;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [15:0]       wdata_q, wdata_d;
   logic [7:0]        low_q, low_d;
   logic              we_q, we_d;
   logic              done_q, done_d;
   logic              busy_q, busy_d;
   logic              drop_q, drop_d;

`ifdef FRAME_LOADER_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             expire;

   // Cycle counter for the HI wait; cleared whenever HI is not the current state.
   always_comb begin
      cnt_d = '0;
      if (state_q == HI) cnt_d = cnt_q + 1'b1;
   end

   assign expire = (state_q == HI) && (cnt_q == CNT_LAST);

   // Timeout counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

   // rx_valid crosses from the tick domain through two flops; the third gives edge history.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q <= 1'b1;
         s2_q <= 1'b1;
         s3_q <= 1'b1;
      end else begin
         s1_q <= rx_valid;
         s2_q <= s1_q;
         s3_q <= s2_q;
      end
   end

   assign strobe = s2_q & ~s3_q;

   // Next-state and datapath: byte pairing, address advance, frame handoff.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      low_d   = low_q;
      drop_d  = 1'b0;
      case (state_q)
         LO: if (strobe) begin
            low_d   = rx_byte;
            state_d = HI;
         end
         HI: begin
            if (strobe) begin
               wdata_d = {rx_byte, low_q};
               state_d = WR;
            end
`ifdef FRAME_LOADER_TIMEOUT_EN
            else if (expire) begin
               low_d   = '0;
               drop_d  = 1'b1;
               state_d = LO;
            end
`endif
         end
         WR: begin
            if (addr_q == LAST_ADDR) begin
               // Frame complete; a byte landing here is already past the frame.
               state_d = DONE;
               drop_d  = strobe;
            end else begin
               addr_d = addr_q + 1'b1;
               if (strobe) begin
                  low_d   = rx_byte;
                  state_d = HI;
               end else begin
                  state_d = LO;
               end
            end
         end
         DONE: begin
            drop_d = strobe;
            if (frame_ack) begin
               addr_d  = '0;
               state_d = LO;
            end
         end
         default: state_d = LO;
      endcase
      we_d   = (state_d == WR);
      busy_d = (state_d == HI) || (state_d == WR);
      done_d = (state_d == DONE);
   end

   // State and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= LO;
         addr_q  <= '0;
         wdata_q <= '0;
         low_q   <= '0;
         we_q    <= 1'b0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
         drop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         low_q   <= low_d;
         we_q    <= we_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
         drop_q  <= drop_d;
      end
   end

   assign mem_we     = we_q;
   assign mem_addr   = addr_q;
   assign mem_wdata  = wdata_q;
   assign frame_done = done_q;
   assign busy       = busy_q;
   assign byte_drop  = drop_q;

endmodule
